// File: rtl/register_scoreboard.sv
// register_scoreboard
//   Issue-stage scoreboard that sits directly upstream of register_manager.
//   It keeps one pending bit per int and per float register for results still
//   in flight in the misc/alu/mem/fpu units. An incoming instruction is held
//   at the issue boundary until its sources (RAW) and destination (WAW) are
//   free. It is then presented, registered, to the operand-read stage.
//
// Ports
//   clk, reset (async, active-low)
//   in_*      : decoded instruction plus in_valid/in_ready handshake
//   out_*     : registered issue slot plus out_valid/out_ready handshake
//   wb_*      : per-unit writeback buses (unit 0 misc, 1 alu, 2 mem, 3 fpu)
//   busy_int, busy_float : pending bitmaps
//   stall_count : cycles in which an offered instruction was held back
module register_scoreboard #(
  parameter int UNITS       = 4,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             in_rs_addr,
  input  logic [4:0]             in_rt_addr,
  input  logic                   in_rs_float,
  input  logic                   in_rt_float,
  input  logic                   in_rs_used,
  input  logic                   in_rt_used,
  input  logic [4:0]             in_rd_addr,
  input  logic                   in_rd_float,
  input  logic                   in_rd_write,
  input  logic [1:0]             in_unit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4:0]             out_rs_addr,
  output logic [4:0]             out_rt_addr,
  output logic                   out_rs_float,
  output logic                   out_rt_float,
  output logic [4:0]             out_rd_addr,
  output logic                   out_rd_float,
  output logic                   out_rd_write,
  output logic [1:0]             out_unit,
  input  logic [UNITS-1:0]       wb_enable,
  input  logic [5*UNITS-1:0]     wb_addr,
  input  logic [UNITS-1:0]       wb_float,
  output logic [31:0]            busy_int,
  output logic [31:0]            busy_float,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic [31:0] busy_int_reg, busy_float_reg;
  logic [31:0] busy_int_next, busy_float_next;
  logic [STALL_CNT_W-1:0] stall_count_reg;

  logic       out_valid_reg;
  logic [4:0] out_rs_addr_reg, out_rt_addr_reg, out_rd_addr_reg;
  logic       out_rs_float_reg, out_rt_float_reg, out_rd_float_reg, out_rd_write_reg;
  logic [1:0] out_unit_reg;

  // Per-unit one-hot clear masks, merged below. Several units may clear
  // different registers in the same cycle.
  logic [31:0] clr_int_u [UNITS];
  logic [31:0] clr_float_u [UNITS];
  logic [31:0] clear_int, clear_float;

  genvar gi;
  generate
    for (gi = 0; gi < UNITS; gi++) begin : g_wb
      logic [31:0] onehot;
      assign onehot          = 32'd1 << wb_addr[gi*5 +: 5];
      assign clr_int_u[gi]   = (wb_enable[gi] && !wb_float[gi]) ? onehot : 32'd0;
      assign clr_float_u[gi] = (wb_enable[gi] &&  wb_float[gi]) ? onehot : 32'd0;
    end
  endgenerate

  always_comb begin
    clear_int   = 32'd0;
    clear_float = 32'd0;
    for (int u = 0; u < UNITS; u++) begin
      clear_int   = clear_int   | clr_int_u[u];
      clear_float = clear_float | clr_float_u[u];
    end
  end

  // A writeback landing in the same cycle makes the register available now;
  // the value is forwarded downstream from the write queue.
  logic [31:0] eff_int, eff_float;
  assign eff_int   = busy_int_reg   & ~clear_int;
  assign eff_float = busy_float_reg & ~clear_float;

  logic rs_hazard, rt_hazard, rd_hazard, hazard, accept;
  assign rs_hazard = in_rs_used  && (in_rs_float ? eff_float[in_rs_addr]
                                     : (in_rs_addr != 5'd0 && eff_int[in_rs_addr]));
  assign rt_hazard = in_rt_used  && (in_rt_float ? eff_float[in_rt_addr]
                                     : (in_rt_addr != 5'd0 && eff_int[in_rt_addr]));
  assign rd_hazard = in_rd_write && (in_rd_float ? eff_float[in_rd_addr]
                                     : (in_rd_addr != 5'd0 && eff_int[in_rd_addr]));
  assign hazard    = rs_hazard || rt_hazard || rd_hazard;

  assign in_ready = !hazard && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  // Set is OR-ed after the clear so a new writer wins over a same-cycle
  // writeback to the same register. Int r0 is hard-wired to never be pending.
  logic [31:0] set_int, set_float;
  assign set_int   = (accept && in_rd_write && !in_rd_float && in_rd_addr != 5'd0)
                     ? (32'd1 << in_rd_addr) : 32'd0;
  assign set_float = (accept && in_rd_write && in_rd_float)
                     ? (32'd1 << in_rd_addr) : 32'd0;

  assign busy_int_next   = ((busy_int_reg & ~clear_int) | set_int) & ~32'd1;
  assign busy_float_next = (busy_float_reg & ~clear_float) | set_float;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_int_reg     <= 32'd0;
      busy_float_reg   <= 32'd0;
      stall_count_reg  <= '0;
      out_valid_reg    <= 1'b0;
      out_rs_addr_reg  <= 5'd0;
      out_rt_addr_reg  <= 5'd0;
      out_rs_float_reg <= 1'b0;
      out_rt_float_reg <= 1'b0;
      out_rd_addr_reg  <= 5'd0;
      out_rd_float_reg <= 1'b0;
      out_rd_write_reg <= 1'b0;
      out_unit_reg     <= 2'd0;
    end else begin
      busy_int_reg   <= busy_int_next;
      busy_float_reg <= busy_float_next;
      if (in_valid && !in_ready)
        stall_count_reg <= stall_count_reg + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      if (accept) begin
        out_valid_reg    <= 1'b1;
        out_rs_addr_reg  <= in_rs_addr;
        out_rt_addr_reg  <= in_rt_addr;
        out_rs_float_reg <= in_rs_float;
        out_rt_float_reg <= in_rt_float;
        out_rd_addr_reg  <= in_rd_addr;
        out_rd_float_reg <= in_rd_float;
        out_rd_write_reg <= in_rd_write;
        out_unit_reg     <= in_unit;
      end else if (out_ready) begin
        // Slot drained; fields keep their last values.
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_rs_addr  = out_rs_addr_reg;
  assign out_rt_addr  = out_rt_addr_reg;
  assign out_rs_float = out_rs_float_reg;
  assign out_rt_float = out_rt_float_reg;
  assign out_rd_addr  = out_rd_addr_reg;
  assign out_rd_float = out_rd_float_reg;
  assign out_rd_write = out_rd_write_reg;
  assign out_unit     = out_unit_reg;
  assign busy_int     = busy_int_reg;
  assign busy_float   = busy_float_reg;
  assign stall_count  = stall_count_reg;

endmodule

// File: tb/tb_register_scoreboard.sv
// Testbench for register_scoreboard: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model built from per-register pending flags.
module tb_register_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs_addr, in_rt_addr, in_rd_addr;
  logic        in_rs_float, in_rt_float, in_rs_used, in_rt_used;
  logic        in_rd_float, in_rd_write;
  logic [1:0]  in_unit;
  logic        out_valid, out_ready;
  logic [4:0]  out_rs_addr, out_rt_addr, out_rd_addr;
  logic        out_rs_float, out_rt_float, out_rd_float, out_rd_write;
  logic [1:0]  out_unit;
  logic [3:0]  wb_enable;
  logic [19:0] wb_addr;
  logic [3:0]  wb_float;
  logic [31:0] busy_int, busy_float;
  logic [31:0] stall_count;

  int tests = 0;
  int fails = 0;

  register_scoreboard #(.UNITS(4), .STALL_CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
    .in_rs_float(in_rs_float), .in_rt_float(in_rt_float),
    .in_rs_used(in_rs_used), .in_rt_used(in_rt_used),
    .in_rd_addr(in_rd_addr), .in_rd_float(in_rd_float),
    .in_rd_write(in_rd_write), .in_unit(in_unit),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs_addr(out_rs_addr), .out_rt_addr(out_rt_addr),
    .out_rs_float(out_rs_float), .out_rt_float(out_rt_float),
    .out_rd_addr(out_rd_addr), .out_rd_float(out_rd_float),
    .out_rd_write(out_rd_write), .out_unit(out_unit),
    .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_float(wb_float),
    .busy_int(busy_int), .busy_float(busy_float),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_int [32];
  bit          m_flt [32];
  bit          m_valid;
  logic [4:0]  m_rs, m_rt, m_rd;
  bit          m_rsf, m_rtf, m_rdf, m_rdw;
  logic [1:0]  m_unit;
  logic [31:0] m_stall;

  function automatic bit reg_pending(input logic [4:0] a, input bit fl);
    bit p;
    p = fl ? m_flt[a] : (a != 0 && m_int[a]);
    for (int u = 0; u < 4; u++)
      if (wb_enable[u] && wb_addr[u*5 +: 5] == a && wb_float[u] == fl)
        p = 0;
    return p;
  endfunction

  function automatic bit exp_ready();
    bit hz;
    hz = (in_rs_used  && reg_pending(in_rs_addr, in_rs_float)) ||
         (in_rt_used  && reg_pending(in_rt_addr, in_rt_float)) ||
         (in_rd_write && reg_pending(in_rd_addr, in_rd_float));
    return !hz && (!m_valid || out_ready);
  endfunction

  function automatic logic [31:0] pack(input bit fl);
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = fl ? m_flt[i] : m_int[i];
    return v;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin m_int[i] = 0; m_flt[i] = 0; end
      m_valid = 0; m_rs = 0; m_rt = 0; m_rd = 0;
      m_rsf = 0; m_rtf = 0; m_rdf = 0; m_rdw = 0; m_unit = 0; m_stall = 0;
    end else begin
      bit r;
      r = exp_ready();
      if (in_valid && !r) m_stall = m_stall + 1;
      for (int u = 0; u < 4; u++)
        if (wb_enable[u]) begin
          if (wb_float[u]) m_flt[wb_addr[u*5 +: 5]] = 0;
          else             m_int[wb_addr[u*5 +: 5]] = 0;
        end
      if (in_valid && r) begin
        m_valid = 1;
        m_rs = in_rs_addr; m_rt = in_rt_addr; m_rd = in_rd_addr;
        m_rsf = in_rs_float; m_rtf = in_rt_float; m_rdf = in_rd_float;
        m_rdw = in_rd_write; m_unit = in_unit;
        if (in_rd_write) begin
          if (in_rd_float) m_flt[in_rd_addr] = 1;
          else if (in_rd_addr != 0) m_int[in_rd_addr] = 1;
        end
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("in_ready",     {31'd0, in_ready},     {31'd0, exp_ready()});
      chk("out_valid",    {31'd0, out_valid},    {31'd0, m_valid});
      chk("out_rs_addr",  {27'd0, out_rs_addr},  {27'd0, m_rs});
      chk("out_rt_addr",  {27'd0, out_rt_addr},  {27'd0, m_rt});
      chk("out_rd_addr",  {27'd0, out_rd_addr},  {27'd0, m_rd});
      chk("out_flags",    {28'd0, out_rs_float, out_rt_float, out_rd_float, out_rd_write},
                          {28'd0, m_rsf, m_rtf, m_rdf, m_rdw});
      chk("out_unit",     {30'd0, out_unit},     {30'd0, m_unit});
      chk("busy_int",     busy_int,   pack(0));
      chk("busy_float",   busy_float, pack(1));
      chk("stall_count",  stall_count, m_stall);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    in_valid = 0; in_rs_addr = 0; in_rt_addr = 0; in_rs_float = 0; in_rt_float = 0;
    in_rs_used = 0; in_rt_used = 0; in_rd_addr = 0; in_rd_float = 0; in_rd_write = 0;
    in_unit = 0; out_ready = 1; wb_enable = 0; wb_addr = 0; wb_float = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue_rd(input logic [4:0] rd, input bit fl, input logic [1:0] unit);
    in_valid = 1; in_rd_addr = rd; in_rd_float = fl; in_rd_write = 1; in_unit = unit;
  endtask

  logic [31:0] base;

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy_int", busy_int, 32'd0);
    chk("rst_stall", stall_count, 32'd0);
    reset = 1;
    tick();

    // Basic issue r3 on alu
    issue_rd(5'd3, 0, 2'd1);
    #1 chk("basic_ready", {31'd0, in_ready}, 32'd1);
    tick(); idle();
    #1;
    chk("basic_out_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_out_rd", {27'd0, out_rd_addr}, 32'd3);
    chk("basic_out_unit", {30'd0, out_unit}, 32'd1);
    chk("basic_busy_int", busy_int, 32'h0000_0008);

    // RAW on f7
    issue_rd(5'd7, 1, 2'd3);
    tick(); idle();
    in_rs_addr = 5'd7; in_rs_float = 0; in_rs_used = 1;
    #1 chk("raw_r7_int_free", {31'd0, in_ready}, 32'd1);
    in_rs_float = 1; in_valid = 1;
    #1 chk("raw_f7_stall", {31'd0, in_ready}, 32'd0);
    base = stall_count;
    repeat (4) tick();
    chk("raw_stall_cnt", stall_count - base, 32'd4);
    wb_enable = 4'b1000; wb_addr = 20'd7 << 15; wb_float = 4'b1000;
    #1 chk("raw_wb_ready", {31'd0, in_ready}, 32'd1);
    tick(); idle();
    #1;
    chk("raw_out_rs", {27'd0, out_rs_addr}, 32'd7);
    chk("raw_out_rs_float", {31'd0, out_rs_float}, 32'd1);
    chk("raw_busy_float", busy_float, 32'd0);

    // Same-cycle set and clear of r9
    issue_rd(5'd9, 0, 2'd1);
    tick();
    wb_enable = 4'b0010; wb_addr = 20'd9 << 5; wb_float = 4'b0000;
    #1 chk("setclr_ready", {31'd0, in_ready}, 32'd1);
    tick(); idle();
    #1 chk("setclr_busy_int", busy_int, 32'h0000_0208);

    // r0 write never becomes pending
    issue_rd(5'd0, 0, 2'd0);
    tick(); idle();
    #1 chk("r0_busy_int", busy_int, 32'h0000_0208);

    // WAW on r4, cleared by the mem port
    issue_rd(5'd4, 0, 2'd2);
    tick();
    #1 chk("waw_stall", {31'd0, in_ready}, 32'd0);
    repeat (2) tick();
    chk("waw_still_stall", {31'd0, in_ready}, 32'd0);
    wb_enable = 4'b0100; wb_addr = 20'd4 << 10;
    #1 chk("waw_wb_ready", {31'd0, in_ready}, 32'd1);
    tick(); idle();
    #1 chk("waw_busy_int", busy_int, 32'h0000_0218);

    // Backpressure
    tick();
    issue_rd(5'd11, 0, 2'd0);
    tick();
    in_rd_addr = 5'd12; out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
      tick();
      chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
      chk("bp_rd_hold", {27'd0, out_rd_addr}, 32'd11);
    end
    out_ready = 1;
    #1 chk("bp_resume_ready", {31'd0, in_ready}, 32'd1);
    tick(); idle();
    #1 chk("bp_next_rd", {27'd0, out_rd_addr}, 32'd12);
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
    tick();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-stream
    issue_rd(5'd5, 0, 2'd1);
    tick(); idle();
    #1 chk("pre_rst_busy5", {31'd0, busy_int[5]}, 32'd1);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    reset = 0;
    #1;
    chk("mid_rst_busy_int", busy_int, 32'd0);
    chk("mid_rst_busy_float", busy_float, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_stall", stall_count, 32'd0);
    chk("mid_rst_rd", {27'd0, out_rd_addr}, 32'd0);
    tick();
    reset = 1;
    tick();

    // Randomized traffic, checked by the compare process
    for (int n = 0; n < 3000; n++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      in_rs_addr  = 5'($urandom_range(0, 7));
      in_rt_addr  = 5'($urandom_range(0, 7));
      in_rd_addr  = 5'($urandom_range(0, 7));
      in_rs_float = 1'($urandom_range(0, 1));
      in_rt_float = 1'($urandom_range(0, 1));
      in_rd_float = 1'($urandom_range(0, 1));
      in_rs_used  = 1'($urandom_range(0, 1));
      in_rt_used  = 1'($urandom_range(0, 1));
      in_rd_write = ($urandom_range(0, 3) != 0);
      in_unit     = 2'($urandom_range(0, 3));
      out_ready   = ($urandom_range(0, 3) != 0);
      for (int u = 0; u < 4; u++) begin
        wb_enable[u]       = ($urandom_range(0, 9) < 3);
        wb_addr[u*5 +: 5]  = 5'($urandom_range(0, 7));
        wb_float[u]        = 1'($urandom_range(0, 1));
      end
      tick();
    end

    idle();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
